// File: rtl/tlc_multi_approach.sv
`default_nettype none
// ============================================================================
// Module      : tlc_multi_approach
// Description : Round-robin N-approach traffic light controller with tick-based
//               countdown, green override and 2-digit seven-segment display.
//               Optional pedestrian walk phase enabled by macro PED_WALK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tlc_multi_approach #(
  parameter int N_APPR   = 4,
  parameter int TW       = 6,
  parameter int YELLOW_T = 10,
  parameter int ALLRED_T = 10,
  parameter int WALK_T   = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 hold,
  input  logic [N_APPR*TW-1:0] green_time,
  input  logic                 load_valid,
  input  logic [TW-1:0]        load_value,
  input  logic                 ped_req,
  output logic [N_APPR-1:0]    red,
  output logic [N_APPR-1:0]    yellow,
  output logic [N_APPR-1:0]    green,
  output logic                 walk,
  output logic [2:0]           active_idx,
  output logic                 phase_done,
  output logic [13:0]          display
);

  typedef enum logic [1:0] {
    S_ALL_RED = 2'd0,
    S_GREEN   = 2'd1,
    S_YELLOW  = 2'd2
`ifdef PED_WALK_EN
    , S_WALK  = 2'd3
`endif
  } state_t;

  localparam logic [TW-1:0] c_yellow_t = TW'(YELLOW_T);
  localparam logic [TW-1:0] c_allred_t = TW'(ALLRED_T);
  localparam logic [TW-1:0] c_one      = TW'(1);
  localparam logic [TW-1:0] c_ten      = TW'(10);
  localparam logic [6:0]    c_dash     = 7'b0000001;

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_idx, w_idx_nxt;
  logic [TW-1:0]   r_timer, w_timer_nxt;
  logic            w_pd;
  logic [TW-1:0]   w_green_sel;
  logic [N_APPR-1:0] w_red, w_yellow, w_green;
  logic [TW-1:0]   w_tens_full, w_units_full;
  logic            w_ped_pend;
  logic            w_walk_enter;

  function automatic logic [TW-1:0] clamp1(input logic [TW-1:0] v);
    return (v == '0) ? c_one : v;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h7E;
      4'd1:    seg7 = 7'h30;
      4'd2:    seg7 = 7'h6D;
      4'd3:    seg7 = 7'h79;
      4'd4:    seg7 = 7'h33;
      4'd5:    seg7 = 7'h5B;
      4'd6:    seg7 = 7'h5F;
      4'd7:    seg7 = 7'h70;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h7B;
      default: seg7 = c_dash;
    endcase
  endfunction

  assign w_green_sel  = green_time[int'(r_idx)*TW +: TW];
  assign w_tens_full  = r_timer / c_ten;
  assign w_units_full = r_timer % c_ten;

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_timer_nxt  = r_timer;
    w_pd         = 1'b0;
    w_walk_enter = 1'b0;
    // An override in GREEN takes priority over a tick, even an expiring one.
    if (load_valid && (r_state == S_GREEN)) begin
      w_timer_nxt = clamp1(load_value);
    end else if (tick && !hold) begin
      if (r_timer > c_one) begin
        w_timer_nxt = r_timer - c_one;
      end else begin
        w_pd = 1'b1;
        case (r_state)
          S_ALL_RED: begin
            w_state_nxt = S_GREEN;
            w_timer_nxt = clamp1(w_green_sel);
          end
          S_GREEN: begin
            w_state_nxt = S_YELLOW;
            w_timer_nxt = c_yellow_t;
          end
          S_YELLOW: begin
            w_idx_nxt   = (r_idx == 3'(N_APPR-1)) ? 3'd0 : r_idx + 3'd1;
            w_state_nxt = S_ALL_RED;
            w_timer_nxt = c_allred_t;
`ifdef PED_WALK_EN
            if (w_ped_pend) begin
              w_state_nxt  = S_WALK;
              w_timer_nxt  = TW'(WALK_T);
              w_walk_enter = 1'b1;
            end
`endif
          end
          default: begin
            w_state_nxt = S_ALL_RED;
            w_timer_nxt = c_allred_t;
          end
        endcase
      end
    end
  end

  // Lamps are registered from the next state so they line up with r_state.
  always_comb begin
    w_red    = '0;
    w_yellow = '0;
    w_green  = '0;
    for (int i = 0; i < N_APPR; i++) begin
      w_green[i]  = (w_state_nxt == S_GREEN)  && (w_idx_nxt == 3'(i));
      w_yellow[i] = (w_state_nxt == S_YELLOW) && (w_idx_nxt == 3'(i));
      w_red[i]    = !(w_green[i] || w_yellow[i]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_ALL_RED;
      r_idx      <= 3'd0;
      r_timer    <= c_allred_t;
      red        <= '1;
      yellow     <= '0;
      green      <= '0;
      phase_done <= 1'b0;
      display    <= {c_dash, c_dash};
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_timer    <= w_timer_nxt;
      red        <= w_red;
      yellow     <= w_yellow;
      green      <= w_green;
      phase_done <= w_pd;
      display    <= hold ? {c_dash, c_dash}
                         : {seg7(w_units_full[3:0]), seg7(w_tens_full[3:0])};
    end
  end

  assign active_idx = r_idx;

`ifdef PED_WALK_EN
  logic r_ped_prev, r_ped_pend;

  assign w_ped_pend = r_ped_pend;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ped_prev <= 1'b0;
      r_ped_pend <= 1'b0;
      walk       <= 1'b0;
    end else begin
      r_ped_prev <= ped_req;
      r_ped_pend <= (r_ped_pend && !w_walk_enter) || (ped_req && !r_ped_prev);
      walk       <= (w_state_nxt == S_WALK);
    end
  end
`else
  logic w_unused_ped;

  assign w_ped_pend   = 1'b0;
  assign w_unused_ped = ped_req ^ w_ped_pend ^ w_walk_enter;
  assign walk         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tlc_multi_approach.sv
`default_nettype none
// ============================================================================
// Module      : tb_tlc_multi_approach
// Description : Directed self-checking bench for tlc_multi_approach (N_APPR=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tlc_multi_approach;

  localparam logic [13:0] c_d_dash = {7'h01, 7'h01};
  localparam logic [13:0] c_d10    = {7'h7E, 7'h30};
  localparam logic [13:0] c_d20    = {7'h7E, 7'h6D};
  localparam logic [13:0] c_d01    = {7'h30, 7'h7E};
  localparam logic [13:0] c_d08    = {7'h7F, 7'h7E};
  localparam logic [13:0] c_d07    = {7'h70, 7'h7E};

  logic        clock = 1'b0;
  logic        reset;
  logic        tick, hold, load_valid, ped_req;
  logic [23:0] green_time;
  logic [5:0]  load_value;
  logic [3:0]  red, yellow, green;
  logic        walk, phase_done;
  logic [2:0]  active_idx;
  logic [13:0] display;

  int vectors    = 0;
  int miscompares = 0;
  int n;

  tlc_multi_approach #(
    .N_APPR(4), .TW(6), .YELLOW_T(10), .ALLRED_T(10), .WALK_T(15)
  ) dut (
    .clock(clock), .reset(reset), .tick(tick), .hold(hold),
    .green_time(green_time), .load_valid(load_valid), .load_value(load_value),
    .ped_req(ped_req), .red(red), .yellow(yellow), .green(green), .walk(walk),
    .active_idx(active_idx), .phase_done(phase_done), .display(display)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Steps until a phase_done pulse is seen; returns the number of edges taken.
  task automatic wait_pd(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (phase_done !== 1'b1 && cnt < 200);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; hold = 1'b0; load_valid = 1'b0;
    load_value = '0; ped_req = 1'b0; green_time = {4{6'd5}};
    repeat (2) step();
    chk("rst_red", red, 4'hF);
    chk("rst_yellow", yellow, 4'h0);
    chk("rst_green", green, 4'h0);
    chk("rst_walk", walk, 1'b0);
    chk("rst_idx", active_idx, 3'd0);
    chk("rst_pd", phase_done, 1'b0);
    chk("rst_disp", display, c_d_dash);

    // Basic round-robin with a tick every cycle
    reset = 1'b0; tick = 1'b1;
    step();
    chk("disp_10", display, c_d10);
    wait_pd(n);
    chk("ar0_len", n, 9);
    chk("g0_green", green, 4'b0001);
    chk("g0_red", red, 4'b1110);
    chk("g0_idx", active_idx, 3'd0);
    step();
    chk("pd_one_cycle", phase_done, 1'b0);
    wait_pd(n);
    chk("g0_len", n, 4);
    chk("y0_yellow", yellow, 4'b0001);
    chk("y0_green", green, 4'b0000);
    wait_pd(n);
    chk("y0_len", n, 10);
    chk("ar_red", red, 4'hF);
    chk("ar_idx1", active_idx, 3'd1);
    wait_pd(n);
    chk("ar_len", n, 10);
    chk("g1_green", green, 4'b0010);
    for (int a = 1; a <= 4; a++) begin
      wait_pd(n);
      chk("loop_g_len", n, 5);
      chk("loop_yellow", yellow, 32'(4'b0001 << (a % 4)));
      wait_pd(n);
      chk("loop_y_len", n, 10);
      chk("loop_idx", active_idx, 32'((a + 1) % 4));
      chk("loop_red", red, 4'hF);
      wait_pd(n);
      chk("loop_ar_len", n, 10);
      chk("loop_green", green, 32'(4'b0001 << ((a + 1) % 4)));
    end

    // Green override, including a load racing an expiring tick
    step();
    load_valid = 1'b1; load_value = 6'd20;
    step();
    chk("load_no_pd", phase_done, 1'b0);
    chk("load_green", green, 4'b0010);
    load_valid = 1'b0; tick = 1'b0;
    step();
    chk("load_disp20", display, c_d20);
    load_valid = 1'b1; load_value = 6'd1;
    step();
    load_value = 6'd0; tick = 1'b1;
    step();
    chk("race_no_pd", phase_done, 1'b0);
    chk("race_green", green, 4'b0010);
    load_valid = 1'b0; tick = 1'b0;
    step();
    chk("clamp_disp01", display, c_d01);
    tick = 1'b1;
    step();
    chk("clamp_pd", phase_done, 1'b1);
    chk("clamp_yellow", yellow, 4'b0010);
    tick = 1'b0; load_valid = 1'b1; load_value = 6'd3;
    step();
    load_valid = 1'b0;
    step();
    chk("load_ign_yellow", display, c_d10);

    // Zero green time clamps to a single tick
    green_time[12 +: 6] = 6'd0;
    green_time[0 +: 6]  = 6'd9;
    tick = 1'b1;
    wait_pd(n);
    chk("y1_len", n, 10);
    chk("ar_idx2", active_idx, 3'd2);
    wait_pd(n);
    chk("ar2_len", n, 10);
    chk("g2_green", green, 4'b0100);
    wait_pd(n);
    chk("g2_zero_len", n, 1);
    chk("y2_yellow", yellow, 4'b0100);

    // Asynchronous reset mid-YELLOW
    step();
    step();
    reset = 1'b1;
    #2;
    chk("mid_rst_red", red, 4'hF);
    chk("mid_rst_yellow", yellow, 4'h0);
    chk("mid_rst_idx", active_idx, 3'd0);
    chk("mid_rst_pd", phase_done, 1'b0);
    chk("mid_rst_disp", display, c_d_dash);
    step();
    reset = 1'b0;
    step();
    chk("post_rst_disp", display, c_d10);

    // Hold freezes the countdown and blanks the display
    wait_pd(n);
    chk("post_rst_ar_len", n, 9);
    chk("g0b_green", green, 4'b0001);
    step();
    hold = 1'b1;
    repeat (7) step();
    chk("hold_disp", display, c_d_dash);
    chk("hold_green", green, 4'b0001);
    chk("hold_pd", phase_done, 1'b0);
    hold = 1'b0; tick = 1'b0;
    step();
    chk("hold_rel_disp08", display, c_d08);
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    chk("hold_rel_disp07", display, c_d07);
    tick = 1'b1;
    wait_pd(n);
    chk("hold_resume_len", n, 7);
    chk("g0b_yellow", yellow, 4'b0001);

    // Pedestrian request during YELLOW
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    wait_pd(n);
    chk("y0b_len", n, 9);
    chk("ped_red", red, 4'hF);
    chk("ped_idx", active_idx, 3'd1);
`ifdef PED_WALK_EN
    chk("walk_on", walk, 1'b1);
    wait_pd(n);
    chk("walk_len", n, 15);
    chk("walk_off", walk, 1'b0);
    chk("walk_ar_red", red, 4'hF);
`else
    chk("walk_tied0", walk, 1'b0);
`endif
    wait_pd(n);
    chk("ped_ar_len", n, 10);
    chk("g1b_green", green, 4'b0010);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
